fpu_norm_lshift: RTL and testbench

Two-stage pipelined left-normalizer for the FP32 datapath, the left-shift counterpart of the right-shift alignment stages.
- Takes an unnormalized 32-bit mantissa with a biased exponent, as produced by add/subtract cancellation, and counts leading zeros.
- Left-shifts the mantissa so its MSB lands at bit 31, and adjusts the exponent, saturating into the denormal range.
- Sits between the mantissa adder and the rounder, behind a valid/ready handshake.

---
 rtl/fpu_pkg.sv | 31 +++
 rtl/fpu_lzc32.sv | 55 +++++
 rtl/fpu_norm_lshift.sv | 168 ++++++++++++++++
 tb/tb_fpu_norm_lshift.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// ---------------------------------------------------------------------------
// fpu_pkg
// Shared types for the FP32 normalizer datapath.
//   fp32_exp_t  : 8-bit biased exponent
//   fp32_mant_t : 32-bit working mantissa
//   shamt_t     : 5-bit left-shift amount (0..31)
//   norm_beat_t : contents of the first pipeline register of fpu_norm_lshift
// ---------------------------------------------------------------------------
package fpu_pkg;

  localparam int unsigned MANT_W = 32;
  localparam int unsigned EXP_W  = 8;
  localparam int unsigned SH_W   = 5;

  // Leading-zero count reported for an all-zero mantissa.
  localparam logic [5:0] LZ_ALL_ZERO = 6'd32;

  typedef logic [EXP_W-1:0]  fp32_exp_t;
  typedef logic [MANT_W-1:0] fp32_mant_t;
  typedef logic [SH_W-1:0]   shamt_t;

  typedef struct packed {
    logic       sign;
    fp32_exp_t  exp;
    fp32_mant_t mant;
    shamt_t     shamt;
    logic       zero;
    logic       denorm;
  } norm_beat_t;

endpackage : fpu_pkg

// File: rtl/fpu_lzc32.sv
// ---------------------------------------------------------------------------
// fpu_lzc32
// Combinational 32-bit leading-zero counter.
//   data : input word
//   lz   : number of leading zeros, 0..32 (32 when data is zero)
// The word is split into eight nibbles; each nibble reports 0..4 leading
// zeros, and the counts are summed from the top down until the first
// non-zero nibble.
// ---------------------------------------------------------------------------
module fpu_lzc32
  import fpu_pkg::*;
(
  input  logic [31:0] data,
  output logic [5:0]  lz
);

  logic [7:0][2:0] nib_lz;   // index 0 is the most significant nibble
  logic [7:0]      nib_zero;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_nib
      logic [3:0] nib;
      assign nib          = data[31-4*gi -: 4];
      assign nib_zero[gi] = (nib == 4'd0);

      always_comb begin
        casez (nib)
          4'b1???: nib_lz[gi] = 3'd0;
          4'b01??: nib_lz[gi] = 3'd1;
          4'b001?: nib_lz[gi] = 3'd2;
          4'b0001: nib_lz[gi] = 3'd3;
          default: nib_lz[gi] = 3'd4;
        endcase
      end
    end
  endgenerate

  // An all-zero nibble contributes 4 and lets the scan continue; the first
  // non-zero nibble contributes its own count and stops it.
  always_comb begin
    logic [5:0] cnt;
    logic       done;
    cnt  = '0;
    done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (!done) begin
        cnt  = cnt + {3'b000, nib_lz[i]};
        done = !nib_zero[i];
      end
    end
    lz = cnt;
  end

endmodule : fpu_lzc32

// File: rtl/fpu_norm_lshift.sv
// ---------------------------------------------------------------------------
// fpu_norm_lshift
// Two-stage pipelined left-normalizer for the FP32 datapath. Counts leading
// zeros of an unnormalized mantissa, shifts its MSB to bit 31 and lowers the
// exponent accordingly, saturating into the denormal range.
//
// Ports:
//   clk_i, rst_ni      : clock (rising edge), asynchronous active-low reset
//   flush_i            : synchronous clear of both pipeline stages
//   in_valid_i/ready_o : input handshake
//   in_sign_i          : sign, passed through
//   in_exp_i           : biased exponent (8 bits)
//   in_mant_i          : unnormalized mantissa (32 bits)
//   out_valid_o/ready_i: output handshake
//   out_sign_o         : sign
//   out_exp_o          : adjusted exponent
//   out_mant_o         : normalized mantissa
//   out_zero_o         : result is exact zero
//   out_denorm_o       : result is denormal (exp 0, mantissa non-zero)
//
// Build option:
//   FPU_NORM_FTZ_EN : when defined, results that would be denormal are
//                     flushed to zero (mant 0, exp 0, zero 1, denorm 0).
// ---------------------------------------------------------------------------
module fpu_norm_lshift
  import fpu_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        flush_i,

  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic        in_sign_i,
  input  logic [7:0]  in_exp_i,
  input  logic [31:0] in_mant_i,

  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic        out_sign_o,
  output logic [7:0]  out_exp_o,
  output logic [31:0] out_mant_o,
  output logic        out_zero_o,
  output logic        out_denorm_o
);

  // -------------------------------------------------------------------------
  // Handshake
  // -------------------------------------------------------------------------
  logic s1_valid;
  logic s2_valid;
  logic s1_adv;
  logic s2_adv;

  assign s2_adv     = !s2_valid || out_ready_i;
  assign s1_adv     = !s1_valid || s2_adv;
  assign in_ready_o = s1_adv;

  // -------------------------------------------------------------------------
  // Stage 1: leading-zero count and exponent adjustment
  // -------------------------------------------------------------------------
  logic [5:0] lz;
  norm_beat_t s1_next;
  norm_beat_t s1_beat;

  fpu_lzc32 u_lzc (
    .data (in_mant_i),
    .lz   (lz)
  );

  always_comb begin
    s1_next      = '0;
    s1_next.sign = in_sign_i;
    s1_next.mant = in_mant_i;
    if (lz == LZ_ALL_ZERO) begin
      // Zero mantissa: incoming mant is already zero, exponent forced to 0.
      s1_next.zero = 1'b1;
    end else if ({3'b000, lz} < {1'b0, in_exp_i}) begin
      // Normal: lz < exp guarantees the subtraction stays positive.
      s1_next.shamt = lz[4:0];
      s1_next.exp   = in_exp_i - {2'b00, lz};
    end else begin
`ifdef FPU_NORM_FTZ_EN
      s1_next.mant = '0;
      s1_next.zero = 1'b1;
`else
      // Denormal: exp <= lz <= 31 here, so exp-1 fits in the shift amount.
      // Shifting by exp-1 leaves the value at the minimum exponent.
      s1_next.denorm = 1'b1;
      if (in_exp_i != 8'd0) begin
        s1_next.shamt = in_exp_i[4:0] - 5'd1;
      end
`endif
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid <= 1'b0;
      s1_beat  <= '0;
    end else begin
      if (flush_i) begin
        s1_valid <= 1'b0;
      end else if (s1_adv) begin
        s1_valid <= in_valid_i;
      end
      // Data loads only on a real transfer so a stalled beat is held.
      if (s1_adv && in_valid_i) begin
        s1_beat <= s1_next;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Stage 2: barrel shift, 16/8/4/2/1 cascade driven by shamt[4:0]
  // -------------------------------------------------------------------------
  logic [5:0][31:0] shift_stage;

  assign shift_stage[0] = s1_beat.mant;

  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_shift
      localparam int unsigned AMT = 16 >> gi;
      assign shift_stage[gi+1] = s1_beat.shamt[4-gi] ? (shift_stage[gi] << AMT)
                                                     : shift_stage[gi];
    end
  endgenerate

  logic        s2_sign;
  logic [7:0]  s2_exp;
  logic [31:0] s2_mant;
  logic        s2_zero;
  logic        s2_denorm;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s2_valid  <= 1'b0;
      s2_sign   <= 1'b0;
      s2_exp    <= '0;
      s2_mant   <= '0;
      s2_zero   <= 1'b0;
      s2_denorm <= 1'b0;
    end else begin
      if (flush_i) begin
        s2_valid <= 1'b0;
      end else if (s2_adv) begin
        s2_valid <= s1_valid;
      end
      // Holding data unless a beat moves keeps outputs stable under stall.
      if (s2_adv && s1_valid) begin
        s2_sign   <= s1_beat.sign;
        s2_exp    <= s1_beat.exp;
        s2_mant   <= shift_stage[5];
        s2_zero   <= s1_beat.zero;
        s2_denorm <= s1_beat.denorm;
      end
    end
  end

  assign out_valid_o  = s2_valid;
  assign out_sign_o   = s2_sign;
  assign out_exp_o    = s2_exp;
  assign out_mant_o   = s2_mant;
  assign out_zero_o   = s2_zero;
  assign out_denorm_o = s2_denorm;

endmodule : fpu_norm_lshift

// File: tb/tb_fpu_norm_lshift.sv
// ---------------------------------------------------------------------------
// tb_fpu_norm_lshift
// Self-checking bench for fpu_norm_lshift: directed steps from the test plan
// followed by randomized traffic checked against a scoreboard whose expected
// values come from a plain-arithmetic normalization model.
// Honours FPU_NORM_FTZ_EN in the reference model.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fpu_norm_lshift;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [7:0]  in_exp;
  logic [31:0] in_mant;
  logic        out_valid;
  logic        out_ready;
  logic        out_sign;
  logic [7:0]  out_exp;
  logic [31:0] out_mant;
  logic        out_zero;
  logic        out_denorm;

  fpu_norm_lshift dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .flush_i      (flush),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .in_sign_i    (in_sign),
    .in_exp_i     (in_exp),
    .in_mant_i    (in_mant),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .out_sign_o   (out_sign),
    .out_exp_o    (out_exp),
    .out_mant_o   (out_mant),
    .out_zero_o   (out_zero),
    .out_denorm_o (out_denorm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [31:0] mant;
    logic        zero;
    logic        denorm;
  } res_t;

  int   checks = 0;
  int   errors = 0;
  res_t sb_q[$];

  // Values to drive on the next tick.
  logic        d_valid, d_sign, d_oready, d_flush;
  logic [7:0]  d_exp;
  logic [31:0] d_mant;
  logic        seen_ready;
  logic        have_hold;
  res_t        hold;
  logic        hold_valid;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference: find the leading one, move it to bit 31 while the exponent
  // stays >= 1; otherwise stop at exponent 1 and report a denormal (exp 0).
  function automatic res_t model(input logic s, input logic [7:0] e, input logic [31:0] m);
    res_t r;
    int   lz;
    int   sh;
    r      = '0;
    r.sign = s;
    lz     = 0;
    while (lz < 32 && m[31-lz] == 1'b0) lz++;
    if (m == 32'd0) begin
      r.zero = 1'b1;
    end else if (lz < int'(e)) begin
      r.exp  = 8'(int'(e) - lz);
      r.mant = m << lz;
    end else begin
      sh       = (e >= 8'd1) ? int'(e) - 1 : 0;
      r.mant   = m << sh;
      r.denorm = 1'b1;
`ifdef FPU_NORM_FTZ_EN
      r.mant   = '0;
      r.zero   = 1'b1;
      r.denorm = 1'b0;
`endif
    end
    return r;
  endfunction

  function automatic res_t observed();
    res_t r;
    r.sign   = out_sign;
    r.exp    = out_exp;
    r.mant   = out_mant;
    r.zero   = out_zero;
    r.denorm = out_denorm;
    return r;
  endfunction

  task automatic drive(input logic v, input logic s, input logic [7:0] e, input logic [31:0] m);
    d_valid = v;
    d_sign  = s;
    d_exp   = e;
    d_mant  = m;
  endtask

  // One clock cycle, entered at the falling edge: apply inputs, score the
  // handshakes that will happen at the coming rising edge, then advance.
  task automatic tick();
    res_t o;
    in_valid  = d_valid;
    in_sign   = d_sign;
    in_exp    = d_exp;
    in_mant   = d_mant;
    out_ready = d_oready;
    flush     = d_flush;
    #1;
    seen_ready = in_ready;
    o = observed();
    if (have_hold) begin
      check("stall_valid", out_valid, hold_valid);
      check("stall_data", o, hold);
    end
    have_hold  = out_valid && !out_ready && !flush;
    hold       = o;
    hold_valid = out_valid;
    if (out_valid && out_ready && !flush) begin
      if (sb_q.size() == 0) begin
        check("out_unexpected", sb_q.size(), 1);
      end else begin
        res_t x;
        x = sb_q.pop_front();
        check("out_beat", o, x);
        $display("beat out: sign=%0d exp=%0d mant=%08h zero=%0d denorm=%0d", o.sign, o.exp, o.mant, o.zero, o.denorm);
      end
    end
    if (flush) begin
      sb_q.delete();
    end else if (in_valid && in_ready) begin
      sb_q.push_back(model(in_sign, in_exp, in_mant));
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // Single beat through an empty pipeline with explicit expected values and
  // the 2-cycle latency checked.
  task automatic single(input string tag, input logic s, input logic [7:0] e, input logic [31:0] m,
                        input logic [7:0] xe, input logic [31:0] xm, input logic xz, input logic xd);
    d_oready = 1'b1;
    d_flush  = 1'b0;
    drive(1'b1, s, e, m);
    tick();
    drive(1'b0, 1'b0, 8'd0, 32'd0);
    check({tag, "_not_yet"}, out_valid, 0);
    tick();
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_sign"}, out_sign, s);
    check({tag, "_exp"}, out_exp, xe);
    check({tag, "_mant"}, out_mant, xm);
    check({tag, "_zero"}, out_zero, xz);
    check({tag, "_denorm"}, out_denorm, xd);
    tick();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_in_ready"}, in_ready, 1);
    check({tag, "_out_sign"}, out_sign, 0);
    check({tag, "_out_exp"}, out_exp, 0);
    check({tag, "_out_mant"}, out_mant, 0);
    check({tag, "_out_zero"}, out_zero, 0);
    check({tag, "_out_denorm"}, out_denorm, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0; in_valid = 1'b0; in_sign = 1'b0; in_exp = '0; in_mant = '0; out_ready = 1'b0;
    d_oready = 1'b1; d_flush = 1'b0;
    drive(1'b0, 1'b0, 8'd0, 32'd0);
    have_hold = 1'b0; hold = '0; hold_valid = 1'b0; seen_ready = 1'b0;

    // Reset state
    #12;
    check_reset_values("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Directed data cases
    single("normal", 1'b0, 8'd100, 32'h0000_8000, 8'd84, 32'h8000_0000, 1'b0, 1'b0);
`ifdef FPU_NORM_FTZ_EN
    single("denorm", 1'b0, 8'd10, 32'h0001_0000, 8'd0, 32'h0000_0000, 1'b1, 1'b0);
`else
    single("denorm", 1'b0, 8'd10, 32'h0001_0000, 8'd0, 32'h0200_0000, 1'b0, 1'b1);
`endif
    single("zero", 1'b1, 8'd50, 32'h0000_0000, 8'd0, 32'h0000_0000, 1'b1, 1'b0);
    single("already", 1'b0, 8'd1, 32'h8000_0001, 8'd1, 32'h8000_0001, 1'b0, 1'b0);

    // Backpressure: three beats offered with the sink stalled
    d_oready = 1'b0;
    drive(1'b1, 1'b0, 8'd200, 32'h0000_00F0); tick();
    check("bp_ready_a", seen_ready, 1);
    drive(1'b1, 1'b1, 8'd20, 32'h0003_0000); tick();
    check("bp_ready_b", seen_ready, 1);
    drive(1'b1, 1'b0, 8'd3, 32'h0000_1234); tick();
    check("bp_ready_c", seen_ready, 0);
    tick();
    check("bp_ready_c2", seen_ready, 0);
    d_oready = 1'b1;
    tick();
    check("bp_release", seen_ready, 1);
    drive(1'b0, 1'b0, 8'd0, 32'd0);
    for (int i = 0; i < 4; i++) tick();
    check("bp_drained", sb_q.size(), 0);

    // Flush with two beats in flight
    d_oready = 1'b0;
    drive(1'b1, 1'b0, 8'd90, 32'h0F00_0000); tick();
    drive(1'b1, 1'b0, 8'd91, 32'h00F0_0000); tick();
    drive(1'b1, 1'b0, 8'd92, 32'h000F_0000);
    d_flush = 1'b1; tick();
    d_flush = 1'b0;
    drive(1'b0, 1'b0, 8'd0, 32'd0);
    check("flush_out_valid", out_valid, 0);
    d_oready = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check("flush_no_beats", out_valid, 0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [31:0] m;
      logic [7:0]  e;
      m = $urandom >> $urandom_range(0, 32);
      e = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 35)) : 8'($urandom_range(0, 254));
      drive($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), e, m);
      d_oready = ($urandom_range(0, 3) != 0);
      d_flush  = ($urandom_range(0, 59) == 0);
      tick();
    end
    d_flush  = 1'b0;
    d_oready = 1'b1;
    drive(1'b0, 1'b0, 8'd0, 32'd0);
    for (int i = 0; i < 6; i++) tick();
    check("rand_drained", sb_q.size(), 0);

    // Asynchronous reset in the middle of a stalled stream
    d_oready = 1'b0;
    drive(1'b1, 1'b1, 8'd77, 32'h0000_0ABC); tick();
    drive(1'b1, 1'b0, 8'd66, 32'h0000_0DEF); tick();
    check("pre_rst_valid", out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("async_rst");
    sb_q.delete();
    have_hold = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    d_oready = 1'b1;
    drive(1'b0, 1'b0, 8'd0, 32'd0);
    #1;
    check("post_rst_in_ready", in_ready, 1);
    tick();
    single("post_rst", 1'b0, 8'd40, 32'h0000_0001, 8'd9, 32'h8000_0000, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_fpu_norm_lshift
